// File: rtl/imem_loader.sv
// Program-image loader: assembles a little-endian byte stream into 32-bit words
// and writes them to instruction memory while holding the PC frozen.
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] word_count,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          wr_en,
    output logic [31:0]   wr_addr,
    output logic [31:0]   wr_data,
    output logic          freeze,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] word_idx_q, word_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;
    logic          cnt_ok;
    logic [CW-1:0] word_idx_inc;

    // A count of 0 or above DEPTH would write nothing or run past the memory.
    assign cnt_ok       = (word_count != '0) && (word_count <= CW'(DEPTH));
    assign word_idx_inc = word_idx_q + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        data_d     = data_q;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cnt_ok) begin
                        count_d    = word_count;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        data_d     = '0;
                        state_d    = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (byte_valid) begin
                    data_d[{byte_idx_q, 3'b000} +: 8] = byte_in;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_inc;
                state_d    = (word_idx_inc == count_q) ? S_DONE : S_LOAD;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign byte_ready = (state_q == S_LOAD);
    assign wr_en      = (state_q == S_WRITE);
    // Address is only driven during the write so it never shows past the last slot.
    assign wr_addr    = wr_en ? 32'({word_idx_q, 2'b00}) : 32'd0;
    assign wr_data    = data_q;
    assign freeze     = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;

endmodule
